alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, shall set the operand/result width and shall match the shared ALU width.
REQ-002 clk  input  1  single clock; all state shall update on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester operation request; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; request i is accepted when req_valid[i] & req_ready[i].
REQ-006 req_op0, req_op1  input  3 each  ALU control code (000 AND, 001 OR, 010 XOR, 011 LSL, 100 ADD, 101 MUL, 110 SUB, 111 pass in2).
REQ-007 req_a0, req_b0, req_a1, req_b1  input  WORD_SIZE each  operands.
REQ-008 rsp_valid  output  2  per-requester result valid.
REQ-009 rsp_ready  input  2  per-requester result accept.
REQ-010 rsp_result  output  WORD_SIZE; rsp_zero  output  1; rsp_ovf  output  1  shared response payload for the granted requester.
REQ-011 alu_in1, alu_in2  output  WORD_SIZE; alu_ctrl  output  3; alu_enable  output  1  drive the shared ALU.
REQ-012 alu_result  input  WORD_SIZE; alu_zero, alu_overflow  input  1  ALU registered outputs, valid the cycle after alu_enable.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, RESP; encoding is free.
REQ-014 IDLE: if any req_valid, shall select winner, assert req_ready for winner only (combinational, that cycle), latch op/operands and grant index, go to ISSUE; else stay.
REQ-015 req_ready shall be 0 in every state other than IDLE; at most one req_ready bit shall be 1 in any cycle.
REQ-016 ISSUE: alu_enable=1 for exactly one cycle with latched operands/op; next WAIT.
REQ-017 WAIT: shall capture alu_result, alu_zero into response registers; next RESP.
REQ-018 rsp_ovf shall capture alu_overflow for ops 100, 101, 110 only and shall be 0 for all other ops (ALU overflow flag is sticky).
REQ-019 RESP: rsp_valid[grant]=1, other bit 0; payload stable; on rsp_ready[grant] go IDLE, else hold.
REQ-020 Latency: accept edge to rsp_valid asserted = 3 cycles; minimum issue interval per arbiter = 4 cycles.
REQ-021 alu_enable shall be 0 outside ISSUE; alu_in1/alu_in2/alu_ctrl shall hold latched values.
REQ-022 Simultaneous req_valid in IDLE: winner per REQ-029/REQ-030.
REQ-023 req_valid deasserted before acceptance: no grant, no state change; rsp_ready on non-granted bit: ignored.
REQ-024 Sticky rsp_valid: shall not drop before handshake, even if requester drops req_valid.

Reset
REQ-025 On rst_n=0 at posedge: state IDLE, req_ready=0, rsp_valid=0, alu_enable=0, alu_in1/alu_in2=0, alu_ctrl=000, rsp_result=0, rsp_zero=0, rsp_ovf=0, grant index 0, round-robin pointer 0.
REQ-026 Reset in any state shall abort the operation; no rsp_valid shall follow for it.
REQ-027 First cycle after rst_n rises: IDLE, accepts requests immediately.

Configuration
REQ-028 Macro ALU_ARB_RR_EN selects arbitration policy.
REQ-029 Defined: round-robin; pointer names preferred requester, shall move to the other requester after each grant.
REQ-030 Undefined: fixed priority, requester 0 always wins; no pointer register.

Structure
REQ-031 WORD_SIZE, the 3-bit ALU op codes, and FSM state constants shall live in the shared define package.
REQ-032 One sub-module natural: alu_arb_pick (2-way arbiter: valids, pointer in -> one-hot grant out); FSM and datapath stay in alu_arbiter.

Verification
REQ-033 Req0 ADD 0x7FFF+0x0001 -> rsp_valid[0] 3 cycles after accept, result 0x8000, ovf 1, zero 0.
REQ-034 Req1 XOR 0x00FF^0x00FF after Req0 overflowing ADD -> result 0x0000, zero 1, ovf 0 (mask).
REQ-035 Both valid continuously, RR_EN defined -> grants alternate 0,1,0,1; undefined -> all grants to 0, Req1 starved.
REQ-036 rsp_ready[0] held low 10 cycles -> rsp_valid[0] and payload stable, req_ready 0 throughout, Req1 not accepted.
REQ-037 rst_n low during WAIT -> next cycle all outputs per REQ-025, no response for aborted op.
REQ-038 Req0 SUB 0x8000-0x0001 -> result 0x7FFF, ovf 1; Req1 MUL 0x0003*0x0004 -> 0x000C, ovf 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared word size, ALU op codes and FSM state encoding for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_LSL  = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Only arithmetic ops refresh the ALU overflow flag; for the rest it is stale.
  function automatic logic op_has_ovf(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way request picker: one-hot grant from the valids, pointer breaks ties.
module alu_arb_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (valid == 2'b11) begin
      grant_c = ptr ? 2'b10 : 2'b01;
    end else begin
      grant_c = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters; one operation in flight at a time.
// ALU_ARB_RR_EN defined: round-robin arbitration; undefined: requester 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned WORD_SIZE = alu_arbiter_pkg::WORD_SIZE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         req_valid,
  output logic [1:0]                         req_ready,
  input  logic [alu_arbiter_pkg::OP_W-1:0]   req_op0,
  input  logic [alu_arbiter_pkg::OP_W-1:0]   req_op1,
  input  logic [WORD_SIZE-1:0]               req_a0,
  input  logic [WORD_SIZE-1:0]               req_b0,
  input  logic [WORD_SIZE-1:0]               req_a1,
  input  logic [WORD_SIZE-1:0]               req_b1,
  output logic [1:0]                         rsp_valid,
  input  logic [1:0]                         rsp_ready,
  output logic [WORD_SIZE-1:0]               rsp_result,
  output logic                               rsp_zero,
  output logic                               rsp_ovf,
  output logic [WORD_SIZE-1:0]               alu_in1,
  output logic [WORD_SIZE-1:0]               alu_in2,
  output logic [alu_arbiter_pkg::OP_W-1:0]   alu_ctrl,
  output logic                               alu_enable,
  input  logic [WORD_SIZE-1:0]               alu_result,
  input  logic                               alu_zero,
  input  logic                               alu_overflow
);
  import alu_arbiter_pkg::*;

  state_e     state_q;
  state_e     state_d;
  logic       grant_q;
  logic       take_c;
  logic       pick_ptr;
  logic [1:0] pick_c;

  alu_arb_pick u_pick (
    .valid   (req_valid),
    .ptr     (pick_ptr),
    .grant_c (pick_c)
  );

`ifdef ALU_ARB_RR_EN
  // Preferred requester flips to the other one after every grant.
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (take_c) begin
      ptr_q <= ~pick_c[1];
    end
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; req_ready is a same-cycle grant, only ever raised in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    take_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && (pick_c != 2'b00)) begin
          req_ready = pick_c;
          take_c    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand latch doubles as the ALU drive; it holds until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q    <= 1'b0;
      alu_ctrl   <= OP_AND;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_enable <= 1'b0;
    end else begin
      alu_enable <= (state_d == ST_ISSUE);
      if (take_c) begin
        grant_q  <= pick_c[1];
        alu_ctrl <= pick_c[1] ? req_op1 : req_op0;
        alu_in1  <= pick_c[1] ? req_a1 : req_a0;
        alu_in2  <= pick_c[1] ? req_b1 : req_b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      rsp_valid <= (state_d == ST_RESP) ? {grant_q, ~grant_q} : 2'b00;
      if (state_q == ST_WAIT) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_ovf    <= alu_overflow & op_has_ovf(alu_ctrl);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU and sticky overflow flag.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned W = 16;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         o;
  } vec_t;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         z;
    logic         o;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [2:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_ovf;
  logic [W-1:0] alu_in1, alu_in2;
  logic [2:0]   alu_ctrl;
  logic         alu_enable;
  logic [W-1:0] alu_result;
  logic         alu_zero, alu_overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  vec_t lane0_q[$];
  vec_t lane1_q[$];
  exp_t exp_q[$];
  int   grant_log[$];

`ifdef ALU_ARB_RR_EN
  int exp_grant[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
  int exp_grant[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif

  alu_arbiter #(.WORD_SIZE(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op0      (req_op0),
    .req_op1      (req_op1),
    .req_a0       (req_a0),
    .req_b0       (req_b0),
    .req_a1       (req_a1),
    .req_b1       (req_b1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_ovf      (rsp_ovf),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_ctrl     (alu_ctrl),
    .alu_enable   (alu_enable),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  // Registered ALU model: outputs update just after the edge that saw alu_enable.
  initial begin
    alu_result   = '0;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
  end

  always @(posedge clk) begin : alu_model
    logic               en;
    logic [2:0]         op;
    logic [W-1:0]       a, b, r;
    logic               ov;
    logic signed [31:0] p;
    en = alu_enable;
    op = alu_ctrl;
    a  = alu_in1;
    b  = alu_in2;
    #1;
    if (en) begin
      ov = alu_overflow;
      p  = 32'sd0;
      case (op)
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_LSL:  r = a << b[3:0];
        OP_ADD:  begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
        OP_SUB:  begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
        OP_MUL:  begin
          p  = $signed(a) * $signed(b);
          r  = p[W-1:0];
          ov = (p != 32'($signed(r)));
        end
        default: r = b;
      endcase
      alu_result   = r;
      alu_zero     = (r == '0);
      alu_overflow = ov;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic add(input int lane, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] res, input logic z, input logic o);
    vec_t v;
    v = '{op: op, a: a, b: b, res: res, z: z, o: o};
    if (lane == 0) lane0_q.push_back(v);
    else           lane1_q.push_back(v);
  endtask

  task automatic accept(input int id, input vec_t v);
    exp_q.push_back('{id: id, res: v.res, z: v.z, o: v.o, acc: cyc});
    grant_log.push_back(id);
    last_acc = cyc;
  endtask

  // Drain outstanding responses, then realign to just after a rising edge.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Present lane heads as long as they have work; caller sits just after a rising edge.
  task automatic run_lanes(input int budget);
    int   n;
    vec_t v;
    n = 0;
    while ((lane0_q.size() != 0 || lane1_q.size() != 0) && n < budget) begin
      req_valid = {lane1_q.size() != 0, lane0_q.size() != 0};
      if (req_valid[0]) begin
        req_op0 = lane0_q[0].op; req_a0 = lane0_q[0].a; req_b0 = lane0_q[0].b;
      end
      if (req_valid[1]) begin
        req_op1 = lane1_q[0].op; req_a1 = lane1_q[0].a; req_b1 = lane1_q[0].b;
      end
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) begin
        v = lane0_q.pop_front();
        accept(0, v);
      end
      if (req_valid[1] && req_ready[1]) begin
        v = lane1_q.pop_front();
        accept(1, v);
      end
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 2'b00;
    chk("lanes_timeout", 32'(lane0_q.size() + lane1_q.size()), 32'd0);
    lane0_q.delete();
    lane1_q.delete();
    drain(budget);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_alu_enable"}, 32'(alu_enable), 32'd0);
    chk({tag, "_alu_in1"},    32'(alu_in1),    32'd0);
    chk({tag, "_alu_in2"},    32'(alu_in2),    32'd0);
    chk({tag, "_alu_ctrl"},   32'(alu_ctrl),   32'd0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_flags"},  32'({rsp_zero, rsp_ovf}), 32'd0);
  endtask

  task automatic stall_ctrl();
    int           n;
    logic [W-1:0] held_res;
    logic [1:0]   held_flags;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", 32'(rsp_valid), 32'd1);
    held_res   = rsp_result;
    held_flags = {rsp_zero, rsp_ovf};
    repeat (10) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", 32'(rsp_result), 32'(held_res));
      chk("stall_flags", 32'({rsp_zero, rsp_ovf}), 32'(held_flags));
    end
    chk("stall_req1_pending", 32'(lane1_q.size()), 32'd1);
    rsp_ready = 2'b11;
  endtask

  // Response monitor: handshake invariants, latency, and scoreboard compare.
  logic [1:0] prev_valid = 2'b00;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prev_valid = 2'b00;
    end else begin
      chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      chk("rsp_valid_onehot", 32'($countones(rsp_valid) <= 1), 32'd1);
      if (rsp_valid != 2'b00) chk("req_ready_in_resp", 32'(req_ready), 32'd0);
      if (rsp_valid != 2'b00 && prev_valid == 2'b00) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else                   chk("rsp_latency", 32'(cyc - exp_q[0].acc), 32'd3);
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected_hs", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_valid), (e.id == 1) ? 32'd2 : 32'd1);
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.o));
        end
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_op0 = '0; req_op1 = '0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Overflowing ADD, then XOR whose stale ALU overflow must be masked.
    add(0, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    add(1, OP_XOR, 16'h00FF, 16'h00FF, 16'h0000, 1'b1, 1'b0);
    run_lanes(100);

    // Requester 0 withholds rsp_ready for 10 cycles; its neighbour's ready is ignored.
    rsp_ready = 2'b10;
    add(0, OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);
    add(1, OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
    fork
      run_lanes(200);
      stall_ctrl();
    join
    rsp_ready = 2'b11;

    add(0, OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    add(1, OP_MUL, 16'h0003, 16'h0004, 16'h000C, 1'b0, 1'b0);
    run_lanes(100);

    add(0, OP_ADD,  16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 1'b1);
    add(0, OP_PASS, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b0);
    add(0, OP_LSL,  16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0);
    run_lanes(100);

    // Reset while the op sits in WAIT: no response may follow for it.
    req_op0 = OP_ADD; req_a0 = 16'h0100; req_b0 = 16'h0200; req_valid = 2'b01;
    @(negedge clk);
    chk("abort_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("abort");
    @(posedge clk);
    #1 rst_n = 1'b1;
    begin
      int rel;
      rel = cyc;
      add(0, OP_OR, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0);
      run_lanes(100);
      chk("post_reset_accept_cycle", 32'(last_acc - rel), 32'd0);
    end

    // Both requesters stay valid: grant order shows the arbitration policy.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst2");
    @(posedge clk);
    #1 rst_n = 1'b1;
    grant_log.delete();
    add(0, OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0);
    add(0, OP_OR,   16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
    add(0, OP_LSL,  16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0);
    add(0, OP_ADD,  16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);
    add(1, OP_ADD,  16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 1'b1);
    add(1, OP_PASS, 16'h5555, 16'hABCD, 16'hABCD, 1'b0, 1'b0);
    add(1, OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    add(1, OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
    run_lanes(200);
    chk("grant_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      chk($sformatf("grant_order_%0d", k), 32'(grant_log[k]), 32'(exp_grant[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
